fixed_point_mac_accum: RTL

Streaming accumulator that sits directly downstream of the pipelined fixed-point multiplier. It sums a group of signed products, where the group is delimited by a last flag, into a guard-bit accumulator. It then rounds and saturates the sum to the output Q format and presents it on a single-entry valid/ready output register. The multiplier has no back-pressure, so this block never stalls its input; a result that is lost is flagged instead.

---
 rtl/fixed_point_mac_accum.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/fixed_point_mac_accum.sv
// Streaming group accumulator for the output of a pipelined fixed-point multiplier.
// Signed products are summed into a guard-bit accumulator until a last flag arrives
// or MAX_TERMS beats have been taken. The closing sum is rounded half toward +inf,
// saturated to OUT_WIDTH and loaded into a single-entry valid/ready output register.
// The input is never stalled. A result that cannot be stored is discarded, and the
// discard is recorded in a sticky flag.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous, active-low reset
//   prod_in         signed product with P_FRAC_BITS fractional bits
//   prod_valid_in   prod_in is valid this cycle
//   prod_last_in    final beat of the group (qualified by prod_valid_in)
//   sum_out         rounded/saturated group sum with OUT_FRAC_BITS fractional bits
//   sum_valid_out   sum_out holds a result that has not been accepted
//   sum_ready_in    consumer accepts sum_out when sum_valid_out is also high
//   sum_sat_out     sum_out was clipped (travels with sum_out)
//   term_count_out  number of beats in the presented group
//   drop_err_out    sticky: a completed result was discarded
//   len_err_out     sticky: a group reached MAX_TERMS without a last flag
module fixed_point_mac_accum #(
  parameter int P_WIDTH        = 18,
  parameter int P_FRAC_BITS    = 14,
  parameter int ACC_GUARD_BITS = 4,
  parameter int OUT_WIDTH      = 16,
  parameter int OUT_FRAC_BITS  = 14,
  parameter int MAX_TERMS      = 16
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [P_WIDTH-1:0]               prod_in,
  input  logic                             prod_valid_in,
  input  logic                             prod_last_in,
  output logic [OUT_WIDTH-1:0]             sum_out,
  output logic                             sum_valid_out,
  input  logic                             sum_ready_in,
  output logic                             sum_sat_out,
  output logic [$clog2(MAX_TERMS+1)-1:0]   term_count_out,
  output logic                             drop_err_out,
  output logic                             len_err_out
);

  localparam int ACC_W = P_WIDTH + ACC_GUARD_BITS;
  localparam int CNT_W = $clog2(MAX_TERMS + 1);
  localparam int SHIFT = P_FRAC_BITS - OUT_FRAC_BITS;

  // Output limits, expressed at the width of the rounding path.
  localparam logic signed [ACC_W:0] SMAX = {{(ACC_W+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SMIN = ~SMAX;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                    state, state_next;
  logic signed [ACC_W-1:0]   acc, acc_next, prod_ext;
  logic        [CNT_W-1:0]   count, count_next;
  logic                      close, forced;
  logic signed [ACC_W:0]     acc_wide, rounded;
  logic                      sat_hi, sat_lo;
  logic        [OUT_WIDTH-1:0] sum_fmt;

  assign prod_ext = {{ACC_GUARD_BITS{prod_in[P_WIDTH-1]}}, prod_in};

  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    close      = 1'b0;
    forced     = 1'b0;
    if (prod_valid_in) begin
      if (state == IDLE) begin
        acc_next   = prod_ext;
        count_next = CNT_W'(1);
      end else begin
        acc_next   = acc + prod_ext;
        count_next = count + 1'b1;
      end
      close      = prod_last_in || (count_next == CNT_W'(MAX_TERMS));
      forced     = !prod_last_in && (count_next == CNT_W'(MAX_TERMS));
      state_next = close ? IDLE : ACCUM;
    end
  end

  // One extra bit so that adding the rounding constant can never wrap.
  assign acc_wide = {acc_next[ACC_W-1], acc_next};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (SHIFT - 1);
      assign rounded = (acc_wide + HALF) >>> SHIFT;
    end else begin : g_no_round
      assign rounded = acc_wide;
    end
  endgenerate

  assign sat_hi  = rounded > SMAX;
  assign sat_lo  = rounded < SMIN;
  assign sum_fmt = sat_hi ? SMAX[OUT_WIDTH-1:0] :
                   sat_lo ? SMIN[OUT_WIDTH-1:0] : rounded[OUT_WIDTH-1:0];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
    end
  end

  // Single-entry output register. A close that coincides with acceptance of the
  // held result reloads it directly, so no bubble appears on sum_valid_out.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sum_out        <= '0;
      sum_valid_out  <= 1'b0;
      sum_sat_out    <= 1'b0;
      term_count_out <= '0;
      drop_err_out   <= 1'b0;
      len_err_out    <= 1'b0;
    end else begin
      if (close && (!sum_valid_out || sum_ready_in)) begin
        sum_out        <= sum_fmt;
        sum_sat_out    <= sat_hi || sat_lo;
        term_count_out <= count_next;
        sum_valid_out  <= 1'b1;
      end else if (sum_ready_in) begin
        sum_valid_out  <= 1'b0;
      end
      if (close && sum_valid_out && !sum_ready_in) begin
        drop_err_out <= 1'b1;
      end
      if (forced) begin
        len_err_out <= 1'b1;
      end
    end
  end

endmodule
